// File: rtl/data_bus_ctrl.sv
// Data-side bus stage for the single-cycle MIPS core.
// It decodes the ALU address into the data RAM, a GPIO port and a
// compare timer. Loads are combinational. Stores commit on the rising clock edge.
module data_bus_ctrl #(
  parameter int          RAM_WORDS = 256,
  parameter int          PRESCALE  = 1,
  parameter logic [31:0] IO_BASE   = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write,
  input  logic        mem_we,
  output logic [31:0] mem_read,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int          AW      = $clog2(RAM_WORDS);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
  localparam logic [2:0] OFF_TMR_CNT  = 3'd2;
  localparam logic [2:0] OFF_TMR_CMP  = 3'd3;
  localparam logic [2:0] OFF_TMR_CTRL = 3'd4;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [2:0]    io_off;
  logic          hit_ram;
  logic          hit_io;

  logic          we_ram;
  logic          we_gpio;
  logic          we_cnt;
  logic          we_cmp;
  logic          we_ctrl;

  logic [7:0]    sync_1;
  logic [7:0]    sync_2;

  logic [15:0]   pre_cnt;
  logic [31:0]   tmr_cnt;
  logic [31:0]   tmr_cmp;
  logic          en;
  logic          auto_reload;
  logic          flag;
  logic          irq_en;
  logic          tick;
  logic          match;

  logic          unused_bits;

  // The byte-lane bits play no part in decoding because every access is a full word.
  assign unused_bits = ^mem_addr[1:0];

  assign ram_idx = mem_addr[AW+1:2];
  assign io_off  = mem_addr[4:2];
  assign hit_ram = (mem_addr[31:AW+2] == '0);
  assign hit_io  = (mem_addr[31:5] == IO_BASE[31:5]);

  assign we_ram  = mem_we && hit_ram;
  assign we_gpio = mem_we && hit_io && (io_off == OFF_GPIO_OUT);
  assign we_cnt  = mem_we && hit_io && (io_off == OFF_TMR_CNT);
  assign we_cmp  = mem_we && hit_io && (io_off == OFF_TMR_CMP);
  assign we_ctrl = mem_we && hit_io && (io_off == OFF_TMR_CTRL);

  assign tick      = en && (pre_cnt == PRE_MAX);
  assign match     = (tmr_cnt == tmr_cmp);
  assign timer_irq = flag && irq_en;

  // Load mux: zero-latency read of the addressed target. Unmapped and reserved addresses return 0.
  always_comb begin
    mem_read = '0;
    if (hit_ram) begin
      mem_read = ram[ram_idx];
    end else if (hit_io) begin
      case (io_off)
        OFF_GPIO_OUT: mem_read = {24'h0, gpio_out};
        OFF_GPIO_IN:  mem_read = {24'h0, sync_2};
        OFF_TMR_CNT:  mem_read = tmr_cnt;
        OFF_TMR_CMP:  mem_read = tmr_cmp;
        OFF_TMR_CTRL: mem_read = {28'h0, irq_en, flag, auto_reload, en};
        default:      mem_read = '0;
      endcase
    end
  end

  // Data RAM store port. There is no reset, so contents stay unknown until written.
  always_ff @(posedge clk) begin
    if (we_ram) begin
      ram[ram_idx] <= mem_write;
    end
  end

  // LED register and the two-stage synchronizer for the switch inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out <= '0;
      sync_1   <= '0;
      sync_2   <= '0;
    end else begin
      sync_1 <= gpio_in;
      sync_2 <= sync_1;
      if (we_gpio) begin
        gpio_out <= mem_write[7:0];
      end
    end
  end

  // Timer. A CPU write to the count beats the tick update, and a match-set of the flag beats a write-1-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt     <= '0;
      tmr_cnt     <= '0;
      tmr_cmp     <= 32'hFFFFFFFF;
      en          <= 1'b0;
      auto_reload <= 1'b0;
      flag        <= 1'b0;
      irq_en      <= 1'b0;
    end else begin
      if (we_ctrl && !mem_write[0]) begin
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= tick ? 16'h0 : pre_cnt + 16'h1;
      end

      if (we_cnt) begin
        tmr_cnt <= mem_write;
      end else if (tick) begin
        tmr_cnt <= (match && auto_reload) ? 32'h0 : tmr_cnt + 32'h1;
      end

      if (we_cmp) begin
        tmr_cmp <= mem_write;
      end

      if (we_ctrl) begin
        en          <= mem_write[0];
        auto_reload <= mem_write[1];
        irq_en      <= mem_write[3];
      end

      if (tick && match) begin
        flag <= 1'b1;
      end else if (we_ctrl && mem_write[2]) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl. It uses one instance with PRESCALE=1 and one with PRESCALE=4.
// Stimulus pushes expected values into a queue.
// A monitor running on the falling edge drains the queue against the live outputs.
module tb_data_bus_ctrl;

  localparam logic [31:0] IO   = 32'hFFFF0000;
  localparam logic [31:0] GOUT = IO + 32'h00;
  localparam logic [31:0] GIN  = IO + 32'h04;
  localparam logic [31:0] CNT  = IO + 32'h08;
  localparam logic [31:0] CMP  = IO + 32'h0C;
  localparam logic [31:0] CTRL = IO + 32'h10;
  localparam logic [31:0] RSVD = IO + 32'h14;

  localparam int K_A_READ = 0;
  localparam int K_A_GPIO = 1;
  localparam int K_A_IRQ  = 2;
  localparam int K_B_READ = 3;
  localparam int K_B_IRQ  = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        reset;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_we, a_irq;
  logic [7:0]  a_gpio_in, a_gpio_out;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_we, b_irq;
  logic [7:0]  b_gpio_in, b_gpio_out;

  chk_t        sb_q[$];
  chk_t        mon_item;
  logic [31:0] mon_act;
  int          n_compared;
  int          n_mismatched;

  data_bus_ctrl #(.RAM_WORDS(256), .PRESCALE(1), .IO_BASE(IO)) dut_a (
    .clk(clk), .reset(reset),
    .mem_addr(a_addr), .mem_write(a_wdata), .mem_we(a_we), .mem_read(a_rdata),
    .gpio_in(a_gpio_in), .gpio_out(a_gpio_out), .timer_irq(a_irq)
  );

  data_bus_ctrl #(.RAM_WORDS(256), .PRESCALE(4), .IO_BASE(IO)) dut_b (
    .clk(clk), .reset(reset),
    .mem_addr(b_addr), .mem_write(b_wdata), .mem_we(b_we), .mem_read(b_rdata),
    .gpio_in(b_gpio_in), .gpio_out(b_gpio_out), .timer_irq(b_irq)
  );

  // Free-running clock with rising edges at 5, 15, 25 and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on each falling edge, drain every expectation queued during this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_item = sb_q.pop_front();
      case (mon_item.kind)
        K_A_READ: mon_act = a_rdata;
        K_A_GPIO: mon_act = {24'h0, a_gpio_out};
        K_A_IRQ:  mon_act = {31'h0, a_irq};
        K_B_READ: mon_act = b_rdata;
        default:  mon_act = {31'h0, b_irq};
      endcase
      n_compared = n_compared + 1;
      if (mon_act !== mon_item.exp) begin
        n_mismatched = n_mismatched + 1;
        $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", mon_item.name, mon_act, mon_item.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_check(input int kind, input logic [31:0] exp, input string name);
    chk_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic bus_write(input int sel, input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      a_addr = addr; a_wdata = data; a_we = 1'b1;
    end else begin
      b_addr = addr; b_wdata = data; b_we = 1'b1;
    end
    step();
    a_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic read_check(input int sel, input logic [31:0] addr, input logic [31:0] exp,
                            input string name);
    if (sel == 0) begin
      a_addr = addr; a_we = 1'b0;
      push_check(K_A_READ, exp, name);
    end else begin
      b_addr = addr; b_we = 1'b0;
      push_check(K_B_READ, exp, name);
    end
    step();
  endtask

  // Directed stimulus sequence.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset     = 1'b0;
    a_addr    = '0; a_wdata = '0; a_we = 1'b0; a_gpio_in = '0;
    b_addr    = '0; b_wdata = '0; b_we = 1'b0; b_gpio_in = '0;

    // Values while reset is held low.
    step();
    push_check(K_A_GPIO, 32'h0, "rst_gpio_out");
    push_check(K_A_IRQ, 32'h0, "rst_irq");
    push_check(K_B_IRQ, 32'h0, "rst_irq_b");
    b_addr = CNT;
    push_check(K_B_READ, 32'h0, "rst_cnt_b");
    read_check(0, CMP, 32'hFFFFFFFF, "rst_cmp");
    read_check(0, CTRL, 32'h0, "rst_ctrl");
    reset = 1'b1;
    step();

    // RAM: ignored low address bits, decode limit, and read-before-write.
    bus_write(0, 32'h0, 32'h11111111);
    bus_write(0, 32'h10, 32'hDEADBEEF);
    bus_write(0, 32'h13, 32'h12345678);
    read_check(0, 32'h10, 32'h12345678, "ram_low_bits");
    read_check(0, 32'h0, 32'h11111111, "ram_word0");
    bus_write(0, 32'h400, 32'hAAAAAAAA);
    read_check(0, 32'h400, 32'h0, "ram_out_of_range");
    read_check(0, 32'h0, 32'h11111111, "ram_no_alias");
    a_addr = 32'h10; a_wdata = 32'hCAFEF00D; a_we = 1'b1;
    push_check(K_A_READ, 32'h12345678, "ram_read_pre_write");
    step();
    a_we = 1'b0;
    read_check(0, 32'h10, 32'hCAFEF00D, "ram_post_write");

    // Unmapped and reserved locations.
    bus_write(0, 32'h00010000, 32'h55555555);
    read_check(0, 32'h00010000, 32'h0, "unmapped_read");
    bus_write(0, RSVD, 32'h77777777);
    read_check(0, RSVD, 32'h0, "reserved_read");

    // GPIO output register and input synchronizer latency.
    bus_write(0, GOUT, 32'h1A5);
    push_check(K_A_GPIO, 32'hA5, "gpio_out_pin");
    read_check(0, GOUT, 32'hA5, "gpio_out_read");
    a_gpio_in = 8'h3C;
    read_check(0, GIN, 32'h0, "gpio_in_edge0");
    read_check(0, GIN, 32'h0, "gpio_in_edge1");
    read_check(0, GIN, 32'h3C, "gpio_in_edge2");
    read_check(0, GIN, 32'h3C, "gpio_in_edge3");

    // One-shot compare with PRESCALE=1.
    bus_write(0, CMP, 32'd5);
    bus_write(0, CNT, 32'd0);
    bus_write(0, CTRL, 32'h9);
    for (int k = 0; k < 6; k++) begin
      push_check(K_A_IRQ, 32'h0, "oneshot_irq_low");
      read_check(0, CNT, 32'(k), "oneshot_cnt");
    end
    push_check(K_A_IRQ, 32'h1, "oneshot_irq_high");
    read_check(0, CNT, 32'd6, "oneshot_cnt_after_match");
    push_check(K_A_IRQ, 32'h1, "oneshot_irq_hold");
    read_check(0, CTRL, 32'hD, "oneshot_ctrl_flag");
    bus_write(0, CTRL, 32'h4);
    push_check(K_A_IRQ, 32'h0, "oneshot_irq_cleared");
    read_check(0, CNT, 32'd9, "oneshot_cnt_stop");
    read_check(0, CTRL, 32'h0, "oneshot_ctrl_cleared");
    read_check(0, CNT, 32'd9, "oneshot_cnt_held");

    // Auto-reload with PRESCALE=4. The flag is cleared in cycle 16 and sets again at cycle 24.
    bus_write(1, CMP, 32'd2);
    bus_write(1, CNT, 32'd0);
    bus_write(1, CTRL, 32'hB);
    for (int i = 0; i < 28; i++) begin
      push_check(K_B_IRQ, ((i >= 12 && i <= 16) || i >= 24) ? 32'h1 : 32'h0, "reload_irq");
      if (i == 16) begin
        bus_write(1, CTRL, 32'hF);
      end else begin
        read_check(1, CNT, 32'((i / 4) % 3), "reload_cnt");
      end
    end

    // Conflict cases: flag set versus write-1-clear, and count write versus tick.
    bus_write(0, CNT, 32'd3);
    bus_write(0, CTRL, 32'h9);
    read_check(0, CNT, 32'd3, "conf_cnt3");
    read_check(0, CNT, 32'd4, "conf_cnt4");
    bus_write(0, CTRL, 32'hD);
    push_check(K_A_IRQ, 32'h1, "conf_set_beats_clear");
    read_check(0, CTRL, 32'hD, "conf_ctrl_flag");
    bus_write(0, CTRL, 32'hD);
    push_check(K_A_IRQ, 32'h0, "conf_clear_ok");
    bus_write(0, CNT, 32'd100);
    read_check(0, CNT, 32'd100, "conf_cnt_write_wins");
    read_check(0, CNT, 32'd101, "conf_cnt_continue");

    // Reset asserted in the middle of a count, between clock edges.
    bus_write(0, CNT, 32'd30);
    for (int k = 0; k < 7; k++) begin
      read_check(0, CNT, 32'(30 + k), "pre_reset_cnt");
    end
    #2;
    reset = 1'b0;
    a_addr = CNT;
    push_check(K_A_READ, 32'h0, "async_rst_cnt");
    push_check(K_A_GPIO, 32'h0, "async_rst_gpio");
    push_check(K_A_IRQ, 32'h0, "async_rst_irq");
    step();
    read_check(0, CMP, 32'hFFFFFFFF, "async_rst_cmp");
    read_check(0, GIN, 32'h0, "async_rst_sync");
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      read_check(0, CNT, 32'h0, "post_rst_cnt_stopped");
    end
    read_check(0, CTRL, 32'h0, "post_rst_ctrl");
    read_check(0, CMP, 32'hFFFFFFFF, "post_rst_cmp");

    step();
    if (sb_q.size() != 0) begin
      n_mismatched = n_mismatched + 1;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
